// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu_pkg
// Brief    : Shared encodings for the MEM-stage load/store unit: Mem_Con
//            codes, funct3 load/store codes, access sizes, FSM state type
//            and legality/alignment helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_lsu_pkg;

  // Mem_Con_EX encodings (2'b11 behaves as "none")
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  // funct3 encodings for loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3 encodings for stores
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Access size carried in funct3[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  // True when funct3 names a supported access of the given direction
  function automatic logic funct3_legal(input logic is_load, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_load) begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                              ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Halfwords need even addresses, words need 4-byte alignment
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational lane steering. Builds byte enables and replicated
//            store data, and extracts/extends load data by address offset.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_rdata_i,
  output logic [31:0] store_wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] load_data_o
);

  logic [31:0] w_shifted;

  // Byte enables and lane-replicated write data by access size
  always_comb begin
    be_o          = 4'b1111;
    store_wdata_o = store_data_i;
    case (funct3_i[1:0])
      SZ_BYTE: begin
        be_o          = 4'b0001 << addr_lo_i;
        store_wdata_o = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_o          = 4'b0011 << addr_lo_i;
        store_wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        be_o          = 4'b1111;
        store_wdata_o = store_data_i;
      end
    endcase
  end

  // Move the addressed lane down to bit 0, then sign/zero extend
  always_comb begin
    w_shifted   = load_rdata_i >> {addr_lo_i, 3'b000};
    load_data_o = w_shifted;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   load_data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  load_data_o = {24'b0, w_shifted[7:0]};
      F3_LHU:  load_data_o = {16'b0, w_shifted[15:0]};
      default: load_data_o = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM-stage load/store unit. Drives a valid/grant data bus, stalls
//            upstream while an access is outstanding, aborts hung accesses
//            via a watchdog, and registers the MEM/WB pipeline outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUresult_EX,
  input  logic [31:0] data2_EX,
  input  logic [1:0]  Mem_Con_EX,
  input  logic [2:0]  funct3_EX,
  input  logic        RegWrite_EX,
  input  logic [1:0]  ResultSrc_EX,
  input  logic [4:0]  rd_EX,
  input  logic [31:0] PC_next_EX,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] ALUresult_WB,
  output logic [31:0] ReadData_WB,
  output logic [31:0] PC_next_WB,
  output logic [1:0]  ResultSrc_WB,
  output logic        RegWrite_WB,
  output logic [4:0]  rd_WB,
  output logic        fault_WB
);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        w_is_load, w_is_store, w_is_access;
  logic        w_fault_pre, w_legal, w_timeout;
  logic        w_complete, w_abort;
  logic [31:0] w_load_data;

  logic [31:0] alu_q, alu_d, rdata_q, rdata_d, pc_q, pc_d;
  logic [1:0]  rsrc_q, rsrc_d;
  logic        regw_q, regw_d, fault_q, fault_d;
  logic [4:0]  rd_q, rd_d;

  // Decode the access and screen it for illegal funct3 / misalignment
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    case (Mem_Con_EX)
      MEM_LOAD:  w_is_load  = 1'b1;
      MEM_STORE: w_is_store = 1'b1;
      MEM_NONE:  w_is_load  = 1'b0;
      default:   w_is_load  = 1'b0;
    endcase
    w_is_access = w_is_load | w_is_store;
    w_fault_pre = w_is_access &
                  (~funct3_legal(w_is_load, funct3_EX) |
                   addr_misaligned(funct3_EX, ALUresult_EX[1:0]));
    w_legal     = w_is_access & ~w_fault_pre;
  end

  // Watchdog fires only while an access is outstanding
  assign w_timeout = (TIMEOUT != 0) && (state_q != ST_IDLE) &&
                     (cnt_q == CNT_W'(TIMEOUT));

  lsu_align u_align (
    .funct3_i      (funct3_EX),
    .addr_lo_i     (ALUresult_EX[1:0]),
    .store_data_i  (data2_EX),
    .load_rdata_i  (dmem_rdata),
    .store_wdata_o (dmem_wdata),
    .be_o          (dmem_be),
    .load_data_o   (w_load_data)
  );

  assign dmem_addr = {ALUresult_EX[31:2], 2'b00};
  assign dmem_we   = dmem_req & w_is_store;
  assign mem_stall = w_legal & ~w_complete;

  // Bus handshake FSM: next state, request and completion strobes
  always_comb begin
    state_d    = state_q;
    dmem_req   = 1'b0;
    w_complete = 1'b0;
    w_abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_legal) begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            if (w_is_store) w_complete = 1'b1;
            else            state_d    = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (!w_legal) begin
          state_d = ST_IDLE;
        end else if (w_timeout) begin
          w_abort    = 1'b1;
          w_complete = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            if (w_is_store) begin
              w_complete = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_RESP;
            end
          end
        end
      end
      ST_RESP: begin
        if (!w_legal) begin
          state_d = ST_IDLE;
        end else if (dmem_rvalid) begin
          w_complete = 1'b1;
          state_d    = ST_IDLE;
        end else if (w_timeout) begin
          w_abort    = 1'b1;
          w_complete = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter runs while outstanding, clears whenever IDLE is current or next
  always_comb begin
    cnt_d = '0;
    if (state_q != ST_IDLE && state_d != ST_IDLE) cnt_d = cnt_q + CNT_W'(1);
  end

  // MEM/WB next values: precheck fault, pass-through, completion or bubble
  always_comb begin
    alu_d   = '0;
    rdata_d = '0;
    pc_d    = '0;
    rsrc_d  = '0;
    regw_d  = 1'b0;
    rd_d    = '0;
    fault_d = 1'b0;
    if (w_fault_pre) begin
      alu_d   = ALUresult_EX;
      pc_d    = PC_next_EX;
      rsrc_d  = ResultSrc_EX;
      rd_d    = rd_EX;
      fault_d = 1'b1;
    end else if (!w_is_access) begin
      alu_d  = ALUresult_EX;
      pc_d   = PC_next_EX;
      rsrc_d = ResultSrc_EX;
      regw_d = RegWrite_EX;
      rd_d   = rd_EX;
    end else if (w_complete) begin
      alu_d   = ALUresult_EX;
      pc_d    = PC_next_EX;
      rsrc_d  = ResultSrc_EX;
      rd_d    = rd_EX;
      regw_d  = RegWrite_EX & ~w_abort;
      fault_d = w_abort;
      rdata_d = (w_is_load && !w_abort) ? w_load_data : 32'b0;
    end
  end

  // FSM state and watchdog counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q   <= '0;
      rdata_q <= '0;
      pc_q    <= '0;
      rsrc_q  <= '0;
      regw_q  <= 1'b0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc_q    <= pc_d;
      rsrc_q  <= rsrc_d;
      regw_q  <= regw_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
    end
  end

  assign ALUresult_WB = alu_q;
  assign ReadData_WB  = rdata_q;
  assign PC_next_WB   = pc_q;
  assign ResultSrc_WB = rsrc_q;
  assign RegWrite_WB  = regw_q;
  assign rd_WB        = rd_q;
  assign fault_WB     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Scoreboard bench for mem_stage_lsu. Expected MEM/WB records are
//            queued when an instruction is presented and compared when the
//            unit completes it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUresult_EX, data2_EX, PC_next_EX;
  logic [1:0]  Mem_Con_EX, ResultSrc_EX;
  logic [2:0]  funct3_EX;
  logic        RegWrite_EX;
  logic [4:0]  rd_EX;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] ALUresult_WB, ReadData_WB, PC_next_WB;
  logic [1:0]  ResultSrc_WB;
  logic        RegWrite_WB;
  logic [4:0]  rd_WB;
  logic        fault_WB;

  mem_stage_lsu #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ALUresult_EX(ALUresult_EX), .data2_EX(data2_EX), .Mem_Con_EX(Mem_Con_EX),
    .funct3_EX(funct3_EX), .RegWrite_EX(RegWrite_EX), .ResultSrc_EX(ResultSrc_EX),
    .rd_EX(rd_EX), .PC_next_EX(PC_next_EX),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .ALUresult_WB(ALUresult_WB), .ReadData_WB(ReadData_WB), .PC_next_WB(PC_next_WB),
    .ResultSrc_WB(ResultSrc_WB), .RegWrite_WB(RegWrite_WB), .rd_WB(rd_WB),
    .fault_WB(fault_WB)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [1:0]  rsrc;
    logic        regw;
    logic [4:0]  rd;
    logic        fault;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  // Bus snapshot taken on the first request cycle of each instruction
  logic [3:0]  s_be;
  logic [31:0] s_wdata, s_addr;
  logic        s_we, s_stable;
  int          s_stalls, s_reqs;

  function automatic wb_t mk_wb(input logic [31:0] alu, input logic [31:0] rdata,
                                input logic [31:0] pc, input logic [1:0] rsrc,
                                input logic regw, input logic [4:0] rd, input logic fault);
    wb_t w;
    w.alu = alu; w.rdata = rdata; w.pc = pc; w.rsrc = rsrc;
    w.regw = regw; w.rd = rd; w.fault = fault;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Present one instruction, play gnt/rvalid schedule, compare on completion
  task automatic run_instr(input logic [1:0] mc, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic regw, input logic [1:0] rsrc, input logic [4:0] rd,
                           input int gnt_at, input int rv_at, input int rv_early,
                           input logic [31:0] rdata);
    logic st;
    bit   done;
    wb_t  e, a;
    Mem_Con_EX = mc; funct3_EX = f3; ALUresult_EX = addr; data2_EX = data;
    RegWrite_EX = regw; ResultSrc_EX = rsrc; rd_EX = rd; PC_next_EX = addr + 32'd4;
    dmem_rdata = rdata;
    s_stalls = 0; s_reqs = 0; s_stable = 1'b1;
    s_be = '0; s_wdata = '0; s_addr = '0; s_we = 1'b0;
    done = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      dmem_gnt    = (cyc == gnt_at);
      dmem_rvalid = (cyc == rv_at) || (cyc == rv_early);
      @(negedge clk);
      st = mem_stall;
      if (dmem_req) begin
        if (s_reqs == 0) begin
          s_be = dmem_be; s_wdata = dmem_wdata; s_addr = dmem_addr; s_we = dmem_we;
        end else if (dmem_be !== s_be || dmem_wdata !== s_wdata ||
                     dmem_addr !== s_addr || dmem_we !== s_we) begin
          s_stable = 1'b0;
        end
        s_reqs++;
      end
      if (st) s_stalls++;
      @(posedge clk); #1;
      if (st) begin
        n_checks++;
        if ({RegWrite_WB, fault_WB, rd_WB} !== 7'b0) begin
          n_errors++;
          $display("FAIL bubble: got regw=%b fault=%b rd=%0d, want all 0",
                   RegWrite_WB, fault_WB, rd_WB);
        end
      end else begin
        done = 1'b1;
        a = {ALUresult_WB, ReadData_WB, PC_next_WB, ResultSrc_WB, RegWrite_WB, rd_WB, fault_WB};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL scoreboard_empty: got wb %h, want a queued record", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_errors++;
            $display("FAIL wb_record: got %h, want %h", a, e);
          end
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL completion_bound: got no completion in 20 cycles, want completion");
      void'(exp_q.pop_front());
    end
    Mem_Con_EX = MEM_NONE; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    Mem_Con_EX = MEM_NONE; funct3_EX = '0; ALUresult_EX = 32'h1234; data2_EX = '0;
    RegWrite_EX = 1'b1; ResultSrc_EX = 2'b11; rd_EX = 5'd9; PC_next_EX = 32'h40;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ALUresult_WB, ReadData_WB, PC_next_WB, ResultSrc_WB, RegWrite_WB, rd_WB, fault_WB} !== '0) begin
      n_errors++;
      $display("FAIL reset_wb: got alu=%h rd=%0d regw=%b, want all 0",
               ALUresult_WB, rd_WB, RegWrite_WB);
    end
    n_checks++;
    if ({dmem_req, mem_stall} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_bus: got req=%b stall=%b, want 0 0", dmem_req, mem_stall);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_store_word();
    exp_q.push_back(mk_wb(32'h100, 32'h0, 32'h104, 2'b00, 1'b0, 5'd0, 1'b0));
    run_instr(MEM_STORE, F3_SW, 32'h100, 32'hDEADBEEF, 1'b0, 2'b00, 5'd0, 0, -1, -1, 32'h0);
    n_checks++;
    if (s_reqs != 1 || s_stalls != 0) begin
      n_errors++;
      $display("FAIL sw_timing: got reqs=%0d stalls=%0d, want 1 0", s_reqs, s_stalls);
    end
    n_checks++;
    if ({s_we, s_be, s_wdata, s_addr} !== {1'b1, 4'b1111, 32'hDEADBEEF, 32'h100}) begin
      n_errors++;
      $display("FAIL sw_bus: got we=%b be=%b wdata=%h addr=%h, want 1 1111 deadbeef 00000100",
               s_we, s_be, s_wdata, s_addr);
    end
  endtask

  task automatic test_load_byte();
    exp_q.push_back(mk_wb(32'h103, 32'hFFFFFF80, 32'h107, 2'b01, 1'b1, 5'd7, 1'b0));
    run_instr(MEM_LOAD, F3_LB, 32'h103, 32'h0, 1'b1, 2'b01, 5'd7, 3, 4, -1, 32'h80FFFFFF);
    n_checks++;
    if (s_stalls != 4 || s_reqs != 4 || !s_stable) begin
      n_errors++;
      $display("FAIL lb_timing: got stalls=%0d reqs=%0d stable=%b, want 4 4 1",
               s_stalls, s_reqs, s_stable);
    end
    n_checks++;
    if ({s_we, s_addr} !== {1'b0, 32'h100}) begin
      n_errors++;
      $display("FAIL lb_bus: got we=%b addr=%h, want 0 00000100", s_we, s_addr);
    end
    // an rvalid pulse while still waiting for grant must be ignored
    exp_q.push_back(mk_wb(32'h103, 32'h00000080, 32'h107, 2'b01, 1'b1, 5'd8, 1'b0));
    run_instr(MEM_LOAD, F3_LBU, 32'h103, 32'h0, 1'b1, 2'b01, 5'd8, 3, 4, 1, 32'h80FFFFFF);
    n_checks++;
    if (s_stalls != 4) begin
      n_errors++;
      $display("FAIL lbu_timing: got stalls=%0d, want 4", s_stalls);
    end
  endtask

  task automatic test_store_half();
    exp_q.push_back(mk_wb(32'h102, 32'h0, 32'h106, 2'b00, 1'b0, 5'd0, 1'b0));
    run_instr(MEM_STORE, F3_SH, 32'h102, 32'h0000ABCD, 1'b0, 2'b00, 5'd0, 1, -1, -1, 32'h0);
    n_checks++;
    if ({s_be, s_wdata} !== {4'b1100, 32'hABCDABCD} || s_stalls != 1 || !s_stable) begin
      n_errors++;
      $display("FAIL sh_bus: got be=%b wdata=%h stalls=%0d stable=%b, want 1100 abcdabcd 1 1",
               s_be, s_wdata, s_stalls, s_stable);
    end
    exp_q.push_back(mk_wb(32'h101, 32'h0, 32'h105, 2'b00, 1'b0, 5'd0, 1'b0));
    run_instr(MEM_STORE, F3_SB, 32'h101, 32'h1234565A, 1'b0, 2'b00, 5'd0, 0, -1, -1, 32'h0);
    n_checks++;
    if ({s_be, s_wdata} !== {4'b0010, 32'h5A5A5A5A}) begin
      n_errors++;
      $display("FAIL sb_bus: got be=%b wdata=%h, want 0010 5a5a5a5a", s_be, s_wdata);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  mcs[4];
    logic [2:0]  f3s[4];
    logic [31:0] ads[4];
    mcs = '{MEM_LOAD, MEM_STORE, MEM_LOAD, MEM_STORE};
    f3s = '{F3_LW, F3_SH, 3'b011, 3'b100};
    ads = '{32'h101, 32'h103, 32'h100, 32'h200};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk_wb(ads[i], 32'h0, ads[i] + 32'd4, 2'b01, 1'b0, 5'd3, 1'b1));
      run_instr(mcs[i], f3s[i], ads[i], 32'hFFFF, 1'b1, 2'b01, 5'd3, 0, 1, -1, 32'h55AA55AA);
      n_checks++;
      if (s_reqs != 0 || s_stalls != 0) begin
        n_errors++;
        $display("FAIL fault_precheck_%0d: got reqs=%0d stalls=%0d, want 0 0", i, s_reqs, s_stalls);
      end
    end
  endtask

  task automatic test_load_extract();
    logic [31:0] w;
    logic [2:0]  f3;
    for (int lane = 0; lane < 4; lane++) begin
      for (int k = 0; k < 4; k++) begin
        f3 = (k == 0) ? F3_LB : (k == 1) ? F3_LBU : (k == 2) ? F3_LH : F3_LHU;
        if (k < 2 || lane[0] == 1'b0) begin
          w = $urandom;
          exp_q.push_back(mk_wb(32'h400 + lane, model_load(f3, lane[1:0], w),
                                32'h404 + lane, 2'b01, 1'b1, 5'd12, 1'b0));
          run_instr(MEM_LOAD, f3, 32'h400 + lane, 32'h0, 1'b1, 2'b01, 5'd12, 0, 1, -1, w);
        end
      end
    end
    exp_q.push_back(mk_wb(32'h200, 32'hCAFEF00D, 32'h204, 2'b01, 1'b1, 5'd13, 1'b0));
    run_instr(MEM_LOAD, F3_LW, 32'h200, 32'h0, 1'b1, 2'b01, 5'd13, 0, 1, -1, 32'hCAFEF00D);
    n_checks++;
    if (s_stalls != 1) begin
      n_errors++;
      $display("FAIL lw_timing: got stalls=%0d, want 1", s_stalls);
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back(mk_wb(32'h300, 32'h0, 32'h304, 2'b01, 1'b0, 5'd4, 1'b1));
    run_instr(MEM_LOAD, F3_LW, 32'h300, 32'h0, 1'b1, 2'b01, 5'd4, 0, -1, -1, 32'h11111111);
    n_checks++;
    if (s_stalls != TO + 1) begin
      n_errors++;
      $display("FAIL timeout_stalls: got %0d, want %0d", s_stalls, TO + 1);
    end
    // late rvalid must not disturb the following instruction
    exp_q.push_back(mk_wb(32'h77, 32'h0, 32'h7B, 2'b00, 1'b1, 5'd6, 1'b0));
    run_instr(MEM_NONE, 3'b000, 32'h77, 32'h0, 1'b1, 2'b00, 5'd6, -1, 0, -1, 32'h22222222);
    n_checks++;
    if (s_stalls != 0) begin
      n_errors++;
      $display("FAIL timeout_late_rvalid: got stalls=%0d, want 0", s_stalls);
    end
  endtask

  task automatic test_reset_mid();
    Mem_Con_EX = MEM_LOAD; funct3_EX = F3_LW; ALUresult_EX = 32'h500; RegWrite_EX = 1'b1;
    ResultSrc_EX = 2'b01; rd_EX = 5'd9; PC_next_EX = 32'h504;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    Mem_Con_EX = MEM_NONE; ALUresult_EX = 32'h0; RegWrite_EX = 1'b0; rd_EX = 5'd0;
    #1;
    n_checks++;
    if ({ALUresult_WB, ReadData_WB, PC_next_WB, ResultSrc_WB, RegWrite_WB, rd_WB, fault_WB,
         dmem_req, mem_stall} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: got alu=%h pc=%h req=%b stall=%b, want all 0",
               ALUresult_WB, PC_next_WB, dmem_req, mem_stall);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(mk_wb(32'h0000_0009, 32'h0, 32'hD, 2'b00, 1'b1, 5'd5, 1'b0));
    run_instr(MEM_NONE, 3'b000, 32'h9, 32'h0, 1'b1, 2'b00, 5'd5, -1, 0, -1, 32'h33333333);
    n_checks++;
    if (s_stalls != 0) begin
      n_errors++;
      $display("FAIL reset_mid_add: got stalls=%0d, want 0", s_stalls);
    end
  endtask

  task automatic test_back_to_back();
    int st[3];
    exp_q.push_back(mk_wb(32'h600, 32'h0, 32'h604, 2'b00, 1'b0, 5'd0, 1'b0));
    run_instr(MEM_STORE, F3_SW, 32'h600, 32'h1, 1'b0, 2'b00, 5'd0, 0, -1, -1, 32'h0);
    st[0] = s_stalls;
    exp_q.push_back(mk_wb(32'h604, 32'h89ABCDEF, 32'h608, 2'b01, 1'b1, 5'd10, 1'b0));
    run_instr(MEM_LOAD, F3_LW, 32'h604, 32'h0, 1'b1, 2'b01, 5'd10, 0, 1, -1, 32'h89ABCDEF);
    st[1] = s_stalls;
    exp_q.push_back(mk_wb(32'h606, 32'h0000CDEF, 32'h60A, 2'b01, 1'b1, 5'd11, 1'b0));
    run_instr(MEM_LOAD, F3_LHU, 32'h606, 32'h0, 1'b1, 2'b01, 5'd11, 0, 1, -1, 32'hCDEF0000);
    st[2] = s_stalls;
    n_checks++;
    if (st[0] != 0 || st[1] != 1 || st[2] != 1) begin
      n_errors++;
      $display("FAIL back_to_back_stalls: got %0d %0d %0d, want 0 1 1", st[0], st[1], st[2]);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_load_extract();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d records, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200us, want finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit. Consumes the EX/MEM pipeline register outputs and drives a valid/grant data-memory bus.
- Aligns and sign/zero-extends load data, then registers the MEM/WB pipeline outputs.
- Raises mem_stall so the hazard unit holds PC/IF_ID/ID_EX/EX_MEM while an access is outstanding.

Parameters:
- TIMEOUT, 255: max cycles an access may stay outstanding before abort with fault; 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ALUresult_EX  in  32  effective address / ALU result
- data2_EX  in  32  store data (rs2)
- Mem_Con_EX  in  2  00 none, 01 load, 10 store, 11 none
- funct3_EX  in  3  access size/sign
- RegWrite_EX  in  1  write-back enable
- ResultSrc_EX  in  2  WB mux select, passed through
- rd_EX  in  5  destination register
- PC_next_EX  in  32  PC+4, passed through
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- mem_stall  out  1  hold upstream stages (combinational)
- ALUresult_WB, ReadData_WB, PC_next_WB  out  32 each  MEM/WB registers
- ResultSrc_WB  out  2  MEM/WB register
- RegWrite_WB  out  1  MEM/WB register
- rd_WB  out  5  MEM/WB register
- fault_WB  out  1  misaligned, illegal funct3, or timeout; one cycle per faulting instruction

Behaviour:
- Reset: async on ~rst. State IDLE, counter 0, all MEM/WB outputs 0, dmem_req 0.
- States: IDLE, REQ (waiting for gnt), RESP (load waiting for rvalid).
- Access = Mem_Con_EX in {01, 10}.
- Legal funct3:
  - load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - store: 000, 001, 010
  - any other value → illegal.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- Fault precheck (illegal or misaligned):
  - no bus request, no stall;
  - next edge: RegWrite_WB=0, fault_WB=1, remaining fields pass through.
- Non-access instruction: no stall; all fields registered next edge; ReadData_WB=0.
- IDLE with a legal access: dmem_req=1 combinationally.
  - Store with gnt: complete this cycle.
  - Store without gnt: → REQ.
  - Load with gnt: → RESP.
  - Load without gnt: → REQ.
- REQ: hold req/we/addr/be/wdata stable until gnt.
  - gnt on store: complete.
  - gnt on load: → RESP.
- RESP: req=0.
  - rvalid: complete; ReadData_WB = extended lane data.
  - rvalid seen in IDLE or REQ is ignored (minimum load latency is 1 cycle).
- mem_stall = legal access AND NOT completing this cycle.
- While stalled, MEM/WB loads a bubble: RegWrite_WB=0, fault_WB=0, rd_WB=0.
- On completion: MEM/WB captures all fields; state → IDLE.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = {4{byte}}.
  - SH: be = 0011 << addr[1:0], wdata = {2{half}}.
  - SW: be = 1111.
- Load extraction: byte/half selected by addr[1:0]; sign- or zero-extended per funct3.
- Watchdog:
  - counter increments each cycle in REQ/RESP, clears in IDLE;
  - at TIMEOUT, abort → IDLE, complete with fault_WB=1, RegWrite_WB=0;
  - a late rvalid is ignored.
- Reset mid-operation: immediate IDLE; any outstanding response is dropped.
- Back-to-back accesses: a new access may start in IDLE on the cycle after completion.

Decomposition:
- Shared package:
  - Mem_Con encodings (MEM_NONE, MEM_LOAD, MEM_STORE);
  - funct3 load/store encodings;
  - state enum IDLE/REQ/RESP.
- Sub-module lsu_align: combinational store lane/be generation and load extract/extend.
- FSM, watchdog and MEM/WB registers stay in mem_stage_lsu.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt immediate → one req cycle, be=1111, no stall, RegWrite_WB=0, fault_WB=0.
- LB addr 0x103, gnt after 2 cycles, rvalid 1 cycle later, rdata 0x80FFFFFF → mem_stall for 4 cycles, ReadData_WB=0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x102, data 0x0000ABCD → be=1100, wdata=0xABCDABCD.
- LW addr 0x101 → no req, no stall, fault_WB=1, RegWrite_WB=0 next cycle.
- Load with gnt and no rvalid, TIMEOUT=4 → stall 5 cycles, then fault_WB=1; later rvalid ignored.
- Assert rst while in RESP → all outputs 0, state IDLE; a following ADD (Mem_Con=00, rd=5) registers with no stall.
